i2c_cmd_sequencer: RTL and testbench

//  Upstream command stage for i2c_top_design: buffers queued I2C byte commands in a FIFO.

---
 rtl/i2c_cmd_sequencer_if.sv | 33 +++
 rtl/i2c_cmd_sequencer.sv | 112 +++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: host command/response and I2C master signals of the command sequencer
interface i2c_cmd_sequencer_if #(
  parameter int DEPTH = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_rw;
  logic [6:0]               cmd_addr;
  logic [7:0]               cmd_data;
  logic                     cmd_last;
  logic                     start;
  logic                     rw;
  logic [6:0]               addr;
  logic [7:0]               master_data_in;
  logic                     more_data;
  logic                     ready;
  logic                     error_flag;
  logic [7:0]               master_data_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [7:0]               rsp_data;
  logic                     rsp_err;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     busy;
  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_last, ready, error_flag, master_data_out, rsp_ready,
    output cmd_ready, start, rw, addr, master_data_in, more_data, rsp_valid, rsp_data, rsp_err, fifo_level, busy
  );
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_last, ready, error_flag, master_data_out, rsp_ready,
    input  cmd_ready, start, rw, addr, master_data_in, more_data, rsp_valid, rsp_data, rsp_err, fifo_level, busy
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: FIFO-buffered I2C byte command issuer with timeout and burst flush on error
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int BUSY_TO = 16,
  parameter int DONE_TO = 4096
) (
  input logic                 clk,
  input logic                 rst,
  i2c_cmd_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(DONE_TO > BUSY_TO ? DONE_TO : BUSY_TO);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TO - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TO - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, FLUSH} state_t;
  state_t state_q, state_d;
  logic [16:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [16:0] cur_q, cur_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d;
  logic [16:0] head;
  logic push, pop, empty;
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign wr_d = wr_q + AW'(push);
  assign rd_d = rd_q + AW'(pop);
  assign cnt_d = cnt_q + LW'(push) - LW'(pop);
  assign bus.cmd_ready = cnt_q != LW'(DEPTH);
  assign bus.start = state_q == ISSUE;
  assign {bus.rw, bus.addr, bus.master_data_in, bus.more_data} = cur_q;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.fifo_level = cnt_q;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q + 1'b1;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !empty && bus.ready;
        state_d = pop ? ISSUE : IDLE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmr_d = '0;
      end
      WAIT_BUSY: begin
        if (!bus.ready) begin
          state_d = WAIT_DONE;
          tmr_d = '0;
        end else if (tmr_q == BUSY_LAST) begin
          state_d = RESP;
          rsp_err_d = 1'b1;
          rsp_data_d = '0;
        end
      end
      WAIT_DONE: begin
        if (bus.ready) begin
          state_d = RESP;
          rsp_err_d = bus.error_flag;
          rsp_data_d = cur_q[16] ? bus.master_data_out : 8'h00;
        end else if (tmr_q == DONE_LAST) begin
          state_d = RESP;
          rsp_err_d = 1'b1;
          rsp_data_d = '0;
        end
      end
      RESP: state_d = !bus.rsp_ready ? RESP : (rsp_err_q && cur_q[0]) ? FLUSH : IDLE;
      FLUSH: begin
        pop = !empty;
        state_d = pop ? RESP : FLUSH;
        rsp_err_d = pop ? 1'b1 : rsp_err_q;
        rsp_data_d = pop ? 8'h00 : rsp_data_q;
      end
      default: state_d = IDLE;
    endcase
    cur_d = pop ? {head[16:1], ~head[0]} : cur_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      cur_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      cur_q <= cur_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data, bus.cmd_last};
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed self-checking bench with a behavioural I2C master model
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int BUSY_TO = 16;
  localparam int DONE_TO = 4096;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  i2c_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();
  i2c_cmd_sequencer #(.DEPTH(DEPTH), .BUSY_TO(BUSY_TO), .DONE_TO(DONE_TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  int n_chk = 0;
  int n_pass = 0;
  int n_start = 0;
  int m_mode = 0;
  logic acc;
  logic [16:0] st_log [64];
  logic [7:0] m_data [64];
  logic m_err [64];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic last, output logic ok);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = rw;
    bus.cmd_addr = a;
    bus.cmd_data = d;
    bus.cmd_last = last;
    ok = bus.cmd_ready;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (bus.start !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_rsp(input int lim, output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic get_rsp(input string tag, output logic [7:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrive"}, 32'(bus.rsp_valid), 32'd1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask
  initial begin : master_model
    int k;
    bus.ready = 1'b1;
    bus.error_flag = 1'b0;
    bus.master_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1) begin
        k = n_start;
        st_log[k % 64] = {bus.rw, bus.addr, bus.master_data_in, bus.more_data};
        n_start++;
        if (m_mode == 2) begin
          @(negedge clk);
          bus.ready = 1'b0;
          while (m_mode == 2) @(negedge clk);
          bus.ready = 1'b1;
        end else if (m_mode != 1) begin
          @(negedge clk);
          bus.ready = 1'b0;
          repeat (3) @(negedge clk);
          bus.master_data_out = m_data[k % 64];
          bus.error_flag = m_err[k % 64];
          bus.ready = 1'b1;
          @(negedge clk);
          bus.error_flag = 1'b0;
          bus.master_data_out = 8'h00;
        end
      end else begin
        bus.ready = m_mode != 3;
      end
    end
  end
  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end
  initial begin : main
    logic [7:0] d, d0;
    logic e, stable;
    logic [16:0] s;
    int n, base, s0;
    logic [7:0] t2_rd [3];
    logic t3_err [4];
    t2_rd = '{8'h11, 8'h22, 8'h33};
    t3_err = '{1'b0, 1'b1, 1'b1, 1'b1};
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_data = '0;
    bus.cmd_last = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m_data[i] = 8'h00;
      m_err[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_outs", 32'({bus.start, bus.rsp_valid, bus.busy, bus.more_data, bus.rsp_err, bus.rsp_data}), 32'd0);
    base = n_start;
    m_data[base % 64] = 8'hEE;
    push(1'b0, 7'h50, 8'hA5, 1'b1, acc);
    wait_start(10, n);
    chk("t1_latency", n, 32'd2);
    get_rsp("t1", d, e);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_data", 32'(d), 32'h00);
    s = st_log[base % 64];
    chk("t1_rw", 32'(s[16]), 32'd0);
    chk("t1_addr", 32'(s[15:9]), 32'h50);
    chk("t1_mdi", 32'(s[8:1]), 32'hA5);
    chk("t1_more", 32'(s[0]), 32'd0);
    chk("t1_starts", n_start - base, 32'd1);
    base = n_start;
    for (int i = 0; i < 3; i++) m_data[(base + i) % 64] = t2_rd[i];
    for (int i = 0; i < 3; i++) push(1'b1, 7'h3C, 8'hFF, i == 2, acc);
    for (int i = 0; i < 3; i++) begin
      get_rsp("t2", d, e);
      s = st_log[(base + i) % 64];
      chk("t2_err", 32'(e), 32'd0);
      chk("t2_data", 32'(d), 32'(t2_rd[i]));
      chk("t2_rw", 32'(s[16]), 32'd1);
      chk("t2_addr", 32'(s[15:9]), 32'h3C);
      chk("t2_more", 32'(s[0]), 32'(i != 2));
    end
    chk("t2_starts", n_start - base, 32'd3);
    base = n_start;
    m_data[(base + 1) % 64] = 8'h77;
    m_err[(base + 1) % 64] = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 7'h2A, 8'(i + 1), i == 3, acc);
    for (int i = 0; i < 4; i++) begin
      get_rsp("t3", d, e);
      chk("t3_err", 32'(e), 32'(t3_err[i]));
      chk("t3_data", 32'(d), 32'h00);
    end
    @(negedge clk);
    chk("t3_starts", n_start - base, 32'd2);
    chk("t3_level", 32'(bus.fifo_level), 32'd0);
    chk("t3_idle", 32'(bus.busy), 32'd0);
    base = n_start;
    m_mode = 1;
    push(1'b0, 7'h11, 8'h00, 1'b1, acc);
    wait_start(10, n);
    chk("t5_busy_start", 32'(bus.start), 32'd1);
    wait_rsp(100, n);
    chk("t5_busy_window", 32'(n >= BUSY_TO && n <= BUSY_TO + 1), 32'd1);
    get_rsp("t5b", d, e);
    chk("t5_busy_err", 32'(e), 32'd1);
    chk("t5_busy_data", 32'(d), 32'h00);
    m_mode = 2;
    push(1'b1, 7'h12, 8'h00, 1'b1, acc);
    wait_start(10, n);
    chk("t5_done_start", 32'(bus.start), 32'd1);
    wait_rsp(DONE_TO + 100, n);
    chk("t5_done_window", 32'(n >= DONE_TO && n <= DONE_TO + 3), 32'd1);
    get_rsp("t5d", d, e);
    chk("t5_done_err", 32'(e), 32'd1);
    chk("t5_done_data", 32'(d), 32'h00);
    m_mode = 0;
    chk("t5_starts", n_start - base, 32'd2);
    m_mode = 3;
    repeat (3) @(negedge clk);
    base = n_start;
    for (int i = 0; i < 9; i++) begin
      push(1'b0, 7'(8'h40 + i), 8'(8'h80 + i), 1'b1, acc);
      chk("t4_accept", 32'(acc), 32'(i < 8));
    end
    @(negedge clk);
    chk("t4_level", 32'(bus.fifo_level), 32'd8);
    chk("t4_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t4_no_start", n_start - base, 32'd0);
    m_mode = 0;
    for (int i = 0; i < 8; i++) begin
      get_rsp("t4", d, e);
      s = st_log[(base + i) % 64];
      chk("t4_err", 32'(e), 32'd0);
      chk("t4_addr", 32'(s[15:9]), 32'(8'h40 + i));
      chk("t4_mdi", 32'(s[8:1]), 32'(8'h80 + i));
    end
    chk("t4_starts", n_start - base, 32'd8);
    chk("t4_level_after", 32'(bus.fifo_level), 32'd0);
    base = n_start;
    m_data[base % 64] = 8'h5A;
    push(1'b1, 7'h21, 8'h00, 1'b1, acc);
    push(1'b0, 7'h22, 8'h33, 1'b1, acc);
    push(1'b0, 7'h23, 8'h44, 1'b1, acc);
    wait_rsp(200, n);
    chk("t6_rsp_arrive", 32'(bus.rsp_valid), 32'd1);
    m_mode = 2;
    d0 = bus.rsp_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      stable = stable & (bus.rsp_valid === 1'b1) & (bus.rsp_data === d0) & (bus.rsp_err === 1'b0);
    end
    chk("t6_hold_stable", 32'(stable), 32'd1);
    chk("t6_hold_data", 32'(bus.rsp_data), 32'h5A);
    chk("t6_hold_no_start", n_start - base, 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    wait_start(20, n);
    chk("t6_second_start", 32'(bus.start), 32'd1);
    repeat (8) @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 32'd1);
    chk("t6_level", 32'(bus.fifo_level), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({bus.start, bus.rw, bus.addr, bus.master_data_in, bus.more_data, bus.rsp_valid, bus.rsp_err, bus.busy}), 32'd0);
    chk("t6_rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    chk("t6_rst_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_mode = 0;
    s0 = n_start;
    repeat (10) @(negedge clk);
    chk("t6_no_restart", n_start - s0, 32'd0);
    chk("t6_idle_after", 32'(bus.busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
